// File: rtl/regdct_reader.sv
// regdct_reader: read-side sequencer that streams COUNT words from the DCT/log-power register file.
// Optional feature: define REGDCT_RD_SUM_EN to add the signed running-sum output `sum`.
module regdct_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6,
  parameter int SUM_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef REGDCT_RD_SUM_EN
  ,
  output logic signed [SUM_W-1:0] sum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2**ADDR_W);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;
  logic                r_done;

  logic [CNT_W-1:0]    w_cnt;
  logic                w_start;
  logic                w_accept;
  logic                w_load;

  assign w_cnt    = (count > MAX_CNT) ? MAX_CNT : count;
  assign w_start  = (r_state == S_IDLE) && start && !abort;
  assign w_accept = r_valid && out_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign w_load   = (r_state == S_STREAM) && (!r_valid || out_ready) && (r_idx < r_cnt);

  assign rf_addr   = r_addr;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_addr <= base_addr;
            r_idx  <= '0;
            r_cnt  <= w_cnt;
            r_busy <= 1'b1;
            if (w_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_accept && r_last) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_load) begin
            r_data  <= rf_data;
            r_valid <= 1'b1;
            r_last  <= ((r_idx + CNT_W'(1)) == r_cnt);
            r_idx   <= r_idx + CNT_W'(1);
            r_addr  <= r_addr + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGDCT_RD_SUM_EN
  function automatic logic signed [SUM_W-1:0] sext_word(input logic [DATA_W-1:0] d);
    return {{(SUM_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  logic signed [SUM_W-1:0] r_sum;
  assign sum = r_sum;

  // Wraps modulo 2^SUM_W; an aborted beat is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if ((r_state == S_STREAM) && !abort && w_accept) begin
      r_sum <= r_sum + sext_word(r_data);
    end
  end
`endif

endmodule

// File: tb/tb_regdct_reader.sv
// Directed testbench for regdct_reader; define REGDCT_RD_SUM_EN to also exercise the sum port.
module tb_regdct_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, out_ready;
  logic [4:0]  base_addr, rf_addr;
  logic [5:0]  count;
  logic [15:0] rf_data, out_data;
  logic        out_valid, out_last, busy, done;
`ifdef REGDCT_RD_SUM_EN
  logic signed [23:0] sum;
  logic signed [23:0] sum_at_done;
`endif

  logic [15:0] rf [32];
  assign rf_data = rf[rf_addr];

  regdct_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef REGDCT_RD_SUM_EN
    , .sum(sum)
`endif
  );

  int checks = 0;
  int errors = 0;

  int          beat_cnt, last_cnt, last_beat, done_cnt, done_cyc, stall_bad;
  bit          timeout;
  logic [4:0]  first_addr;
  logic [15:0] beat_dat[$];
  int          beat_cyc[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] b, input logic [5:0] n);
    base_addr = b; count = n; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Observes the stream from the cycle after the start edge until busy falls.
  task automatic collect(input int mode, input int max_cyc);
    logic pv, pr, pl;
    logic [15:0] pd;
    logic [4:0] pa;
    beat_cnt = 0; last_cnt = 0; last_beat = -1; done_cnt = 0; done_cyc = -1;
    stall_bad = 0; timeout = 1'b1; beat_dat.delete(); beat_cyc.delete();
    first_addr = rf_addr; pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pa = '0;
    for (int c = 0; c < max_cyc; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (pv && !pr && (out_data !== pd || out_last !== pl || rf_addr !== pa)) stall_bad++;
      if (done === 1'b1) begin
        done_cnt++; done_cyc = c;
`ifdef REGDCT_RD_SUM_EN
        sum_at_done = sum;
`endif
      end
      if (busy !== 1'b1 && c > 0) begin
        timeout = 1'b0;
        break;
      end
      if (out_valid === 1'b1 && out_ready) begin
        beat_dat.push_back(out_data); beat_cyc.push_back(c);
        if (out_last === 1'b1) begin last_cnt++; last_beat = beat_cnt; end
        beat_cnt++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pa = rf_addr;
      tick;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1; base_addr = 5'd0; count = 6'd5;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rf_addr); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
`ifdef REGDCT_RD_SUM_EN
    checks++; if (sum !== 24'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum); end
`endif
    start = 1'b0; reset = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_stream23;
    logic [15:0] got;
    int gc;
    do_start(5'd0, 6'd23);
    checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL s23_addr0 got %0d want 0", rf_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s23_busy got %b want 1", busy); end
    collect(0, 60);
    checks++; if (timeout) begin errors++; $display("FAIL s23_timeout got 1 want 0"); end
    checks++; if (beat_cnt !== 23) begin errors++; $display("FAIL s23_beats got %0d want 23", beat_cnt); end
    for (int k = 0; k < 23; k++) begin
      got = (k < beat_cnt) ? beat_dat[k] : 16'hxxxx;
      gc  = (k < beat_cnt) ? beat_cyc[k] : -1;
      checks++;
      if (got !== rf[k] || gc !== k + 1) begin
        errors++; $display("FAIL s23_beat%0d got %0d@%0d want %0d@%0d", k, got, gc, rf[k], k + 1);
      end
    end
    checks++; if (last_cnt !== 1 || last_beat !== 22) begin errors++; $display("FAIL s23_last got %0d/%0d want 1/22", last_cnt, last_beat); end
    checks++; if (done_cnt !== 1 || done_cyc !== 24) begin errors++; $display("FAIL s23_done got %0d@%0d want 1@24", done_cnt, done_cyc); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp [4];
    logic [15:0] got;
    exp[0] = 16'd90; exp[1] = 16'd93; exp[2] = 16'd0; exp[3] = 16'd3;
    do_start(5'd30, 6'd4);
    collect(0, 30);
    checks++; if (beat_cnt !== 4) begin errors++; $display("FAIL wrap_beats got %0d want 4", beat_cnt); end
    for (int k = 0; k < 4; k++) begin
      got = (k < beat_cnt) ? beat_dat[k] : 16'hxxxx;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL wrap_beat%0d got %0d want %0d", k, got, exp[k]); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== 5) begin errors++; $display("FAIL wrap_done got %0d@%0d want 1@5", done_cnt, done_cyc); end
  endtask

  task automatic test_stall;
    logic [15:0] got;
    do_start(5'd5, 6'd3);
    collect(1, 40);
    checks++; if (beat_cnt !== 3) begin errors++; $display("FAIL stall_beats got %0d want 3", beat_cnt); end
    for (int k = 0; k < 3; k++) begin
      got = (k < beat_cnt) ? beat_dat[k] : 16'hxxxx;
      checks++; if (got !== rf[5 + k]) begin errors++; $display("FAIL stall_beat%0d got %0d want %0d", k, got, rf[5 + k]); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", stall_bad); end
    checks++; if (last_beat !== 2 || done_cnt !== 1) begin errors++; $display("FAIL stall_last got %0d/%0d want 2/1", last_beat, done_cnt); end
  endtask

  task automatic test_abort;
    int dseen;
    do_start(5'd0, 6'd10);
    tick; tick;
    checks++; if (out_valid !== 1'b1 || out_data !== rf[1]) begin errors++; $display("FAIL abort_pre got %b/%0d want 1/%0d", out_valid, out_data, rf[1]); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop got %b/%b want 0/0", out_valid, busy); end
    dseen = 0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) dseen++;
      tick;
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", dseen); end
    do_start(5'd3, 6'd2);
    collect(0, 20);
    checks++; if (beat_cnt !== 2 || done_cnt !== 1) begin errors++; $display("FAIL abort_restart got %0d/%0d want 2/1", beat_cnt, done_cnt); end
    checks++; if (beat_cnt == 2 && (beat_dat[0] !== rf[3] || beat_dat[1] !== rf[4])) begin errors++; $display("FAIL abort_restart_data got %0d,%0d want %0d,%0d", beat_dat[0], beat_dat[1], rf[3], rf[4]); end
  endtask

  task automatic test_start_abort_idle;
    base_addr = 5'd0; count = 6'd5; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sa_busy got %b want 0", busy); end
    tick;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sa_valid got %b/%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_count_edges;
    logic [15:0] got;
    int bad;
    do_start(5'd7, 6'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL c0_pulse got %b%b%b want 110", busy, done, out_valid); end
    tick;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL c0_after got %b%b%b want 000", busy, done, out_valid); end
    do_start(5'd8, 6'd40);
    collect(0, 80);
    checks++; if (beat_cnt !== 32) begin errors++; $display("FAIL c40_beats got %0d want 32", beat_cnt); end
    checks++; if (last_beat !== 31 || done_cnt !== 1) begin errors++; $display("FAIL c40_last got %0d/%0d want 31/1", last_beat, done_cnt); end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      got = (k < beat_cnt) ? beat_dat[k] : 16'hxxxx;
      if (got !== rf[(8 + k) % 32]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL c40_data got %0d bad beats want 0", bad); end
  endtask

  task automatic test_sum;
    logic [15:0] exp [4];
    logic [15:0] got;
    exp[0] = 16'd100; exp[1] = 16'hFFCE; exp[2] = 16'd7; exp[3] = 16'hFFFF;
    for (int k = 0; k < 4; k++) rf[k] = exp[k];
    do_start(5'd0, 6'd4);
    collect(0, 30);
    for (int k = 0; k < 4; k++) begin
      got = (k < beat_cnt) ? beat_dat[k] : 16'hxxxx;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL sum_beat%0d got %0d want %0d", k, got, exp[k]); end
    end
`ifdef REGDCT_RD_SUM_EN
    checks++; if (sum_at_done !== 24'sd56) begin errors++; $display("FAIL sum_final got %0d want 56", sum_at_done); end
`endif
  endtask

  task automatic test_reset_midstream;
    int bad;
    do_start(5'd0, 6'd10);
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl got %b%b%b%b want 0000", out_valid, busy, done, out_last); end
    checks++; if (rf_addr !== 5'd0 || out_data !== 16'd0) begin errors++; $display("FAIL rst_mid_data got %0d/%0d want 0/0", rf_addr, out_data); end
`ifdef REGDCT_RD_SUM_EN
    checks++; if (sum !== 24'sd0) begin errors++; $display("FAIL rst_mid_sum got %0d want 0", sum); end
`endif
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 16'(i * 3);
    test_reset;
    test_stream23;
    test_wrap;
    test_stall;
    test_abort;
    test_start_abort_idle;
    test_count_edges;
    test_sum;
    test_reset_midstream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
